// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and default constants for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } arb_owner_t;

    localparam int ARB_DEF_LATENCY = 1;
    localparam int ARB_DEF_STARVE  = 4;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_grant_logic.sv
`default_nettype none
// ============================================================================
// Module      : arb_grant_logic
// Description : Data-priority grant decision with a saturating fetch
//               starvation counter that forces a fetch grant at the limit.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_grant_logic
    import arb_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_DEF_STARVE
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic if_req_valid,
    input  logic d_req_valid,
    output logic grant_if,
    output logic grant_d
);

    localparam logic [7:0] c_starve_limit = 8'(STARVE_LIMIT);

    logic [7:0] r_starve_cnt;
    logic       w_force_if;

    always_comb begin
        w_force_if = (r_starve_cnt == c_starve_limit);
        grant_d    = idle && d_req_valid && !(if_req_valid && w_force_if);
        grant_if   = idle && if_req_valid && !grant_d;
    end

    // Counts data grants that overtook a waiting fetch; any fetch grant clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 8'd0;
        end else if (grant_if) begin
            r_starve_cnt <= 8'd0;
        end else if (grant_d && if_req_valid && (r_starve_cnt != 8'hFF)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between fetch and load/store with a
//               valid/ready request side and one-cycle response pulses.
//               Optional macro ARB_PERF_CNT_EN adds grant/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = ARB_DEF_LATENCY,
    parameter int STARVE_LIMIT = ARB_DEF_STARVE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic                  if_resp_valid,
    output logic [DATA_WIDTH-1:0] if_resp_data,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_rdata,
    output logic                  mem_en,
    output logic                  mem_rd_wr,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  busy
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_if_grants,
    output logic [31:0]           perf_d_grants,
    output logic [31:0]           perf_if_stall
`endif
);

    localparam logic [3:0] c_lat_m1 = 4'(MEM_LATENCY - 1);

    arb_state_t            r_state;
    arb_owner_t            r_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_wait_cnt;
    logic                  r_drop;
    logic                  r_if_resp_valid;
    logic [DATA_WIDTH-1:0] r_if_resp_data;
    logic                  r_d_resp_valid;
    logic [DATA_WIDTH-1:0] r_d_resp_rdata;

    logic w_idle;
    logic w_last;
    logic w_grant_if;
    logic w_grant_d;

    assign w_idle = (r_state == ARB_IDLE);
    assign w_last = (r_state == ARB_WAIT) && (r_wait_cnt == 4'd0);

    arb_grant_logic #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk          (clk),
        .rst          (rst),
        .idle         (w_idle),
        .if_req_valid (if_req_valid),
        .d_req_valid  (d_req_valid),
        .grant_if     (w_grant_if),
        .grant_d      (w_grant_d)
    );

    assign if_req_ready = w_grant_if;
    assign d_req_ready  = w_grant_d;

    always_comb begin
        mem_en         = (r_state == ARB_WAIT);
        mem_rd_wr      = 1'b1;
        mem_read_addr  = '0;
        mem_write_addr = '0;
        mem_write_data = '0;
        if (r_state == ARB_WAIT) begin
            mem_rd_wr = ~r_we;
            if (r_we) begin
                mem_write_addr = r_addr;
                mem_write_data = r_wdata;
            end else begin
                mem_read_addr = r_addr;
            end
        end
    end

    assign busy = (r_state == ARB_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_owner    <= OWNER_IF;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_wait_cnt <= 4'd0;
            r_drop     <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_grant_d || w_grant_if) begin
                        r_state    <= ARB_WAIT;
                        r_owner    <= w_grant_d ? OWNER_D : OWNER_IF;
                        r_addr     <= w_grant_d ? d_addr : if_addr;
                        r_we       <= w_grant_d && d_we;
                        r_wdata    <= w_grant_d ? d_wdata : '0;
                        r_wait_cnt <= c_lat_m1;
                    end
                end
                ARB_WAIT: begin
                    if ((r_owner == OWNER_IF) && if_flush) begin
                        r_drop <= 1'b1;
                    end
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= ARB_IDLE;
                        r_drop  <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    // A flush in the final WAIT cycle still squashes, so it is folded in directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_resp_valid <= 1'b0;
            r_if_resp_data  <= '0;
            r_d_resp_valid  <= 1'b0;
            r_d_resp_rdata  <= '0;
        end else begin
            r_if_resp_valid <= 1'b0;
            r_d_resp_valid  <= 1'b0;
            if (w_last) begin
                if (r_owner == OWNER_IF) begin
                    r_if_resp_data  <= mem_read_data;
                    r_if_resp_valid <= ~(r_drop | if_flush);
                end else begin
                    r_d_resp_rdata <= r_we ? '0 : mem_read_data;
                    r_d_resp_valid <= 1'b1;
                end
            end
        end
    end

    assign if_resp_valid = r_if_resp_valid;
    assign if_resp_data  = r_if_resp_data;
    assign d_resp_valid  = r_d_resp_valid;
    assign d_resp_rdata  = r_d_resp_rdata;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_if_grants;
    logic [31:0] r_perf_d_grants;
    logic [31:0] r_perf_if_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_if_grants <= 32'd0;
            r_perf_d_grants  <= 32'd0;
            r_perf_if_stall  <= 32'd0;
        end else begin
            if (w_grant_if) begin
                r_perf_if_grants <= r_perf_if_grants + 32'd1;
            end
            if (w_grant_d) begin
                r_perf_d_grants <= r_perf_d_grants + 32'd1;
            end
            if (if_req_valid && !w_grant_if) begin
                r_perf_if_stall <= r_perf_if_stall + 32'd1;
            end
        end
    end

    assign perf_if_grants = r_perf_if_grants;
    assign perf_d_grants  = r_perf_d_grants;
    assign perf_if_stall  = r_perf_if_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter against a
//               timestamp-based transaction model and a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int LAT   = 3;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_flush, if_resp_valid;
    logic [31:0] if_addr, if_resp_data;
    logic        d_req_valid, d_req_ready, d_we, d_resp_valid;
    logic [31:0] d_addr, d_wdata, d_resp_rdata;
    logic        mem_en, mem_rd_wr, busy;
    logic [31:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .MEM_LATENCY  (LAT),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_addr        (if_addr),
        .if_flush       (if_flush),
        .if_resp_valid  (if_resp_valid),
        .if_resp_data   (if_resp_data),
        .d_req_valid    (d_req_valid),
        .d_req_ready    (d_req_ready),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_resp_valid   (d_resp_valid),
        .d_resp_rdata   (d_resp_rdata),
        .mem_en         (mem_en),
        .mem_rd_wr      (mem_rd_wr),
        .mem_read_addr  (mem_read_addr),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Memory seen by the DUT, and the reference contents the model expects.
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];

    // Model state: one transaction, identified by its accept cycle.
    int          cyc;
    bit          m_has;
    int          m_acc;
    bit          m_own_d, m_we, m_drop;
    logic [31:0] m_addr, m_wdata, m_data, m_if_data, m_d_data;
    int          m_starve;
    bit          e_busy, e_gd, e_gif;
    bit          wr_pend;
    logic [31:0] wr_a, wr_d;

    // Observations of the last sampled cycle, used by directed checks.
    bit          o_ifr, o_dr, o_ifresp, o_dresp, o_rdwr;
    logic [31:0] o_ifrdata, o_drdata;

    function automatic logic [31:0] fill(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_mem();
        if (mem_en && mem_rd_wr)
            mem_read_data = bmem.exists(mem_read_addr) ? bmem[mem_read_addr] : fill(mem_read_addr);
        else
            mem_read_data = 32'h0BAD0BAD;
    endtask

    task automatic model_reset();
        m_has = 0; m_starve = 0; m_drop = 0; m_own_d = 0; m_we = 0;
        m_addr = 0; m_wdata = 0; m_data = 0; m_if_data = 0; m_d_data = 0;
    endtask

    task automatic compare();
        bit resp;
        e_busy = m_has && (cyc > m_acc) && (cyc <= m_acc + LAT);
        resp   = m_has && (cyc == m_acc + LAT + 1);
        e_gd   = !e_busy && d_req_valid && !(if_req_valid && (m_starve == LIMIT));
        e_gif  = !e_busy && if_req_valid && !e_gd;
        chk("busy",           32'(busy),          32'(e_busy));
        chk("mem_en",         32'(mem_en),        32'(e_busy));
        chk("mem_rd_wr",      32'(mem_rd_wr),     32'(!(e_busy && m_we)));
        chk("mem_read_addr",  mem_read_addr,      (e_busy && !m_we) ? m_addr : 32'h0);
        chk("mem_write_addr", mem_write_addr,     (e_busy && m_we) ? m_addr : 32'h0);
        chk("mem_write_data", mem_write_data,     (e_busy && m_we) ? m_wdata : 32'h0);
        chk("if_req_ready",   32'(if_req_ready),  32'(e_gif));
        chk("d_req_ready",    32'(d_req_ready),   32'(e_gd));
        chk("if_resp_valid",  32'(if_resp_valid), 32'(resp && !m_own_d && !m_drop));
        chk("d_resp_valid",   32'(d_resp_valid),  32'(resp && m_own_d));
        chk("if_resp_data",   if_resp_data,       m_if_data);
        chk("d_resp_rdata",   d_resp_rdata,       m_d_data);
        wr_pend = mem_en && !mem_rd_wr;
        wr_a = mem_write_addr; wr_d = mem_write_data;
        o_ifr = if_req_ready; o_dr = d_req_ready; o_rdwr = mem_rd_wr;
        o_ifresp = if_resp_valid; o_dresp = d_resp_valid;
        o_ifrdata = if_resp_data; o_drdata = d_resp_rdata;
    endtask

    task automatic update();
        if (wr_pend) bmem[wr_a] = wr_d;
        if (e_busy && !m_own_d && if_flush) m_drop = 1;
        if (e_busy && (cyc == m_acc + LAT)) begin
            if (m_own_d) m_d_data = m_data;
            else         m_if_data = m_data;
        end
        if (e_gd || e_gif) begin
            if (e_gd) begin
                if (if_req_valid && m_starve < 255) m_starve++;
            end else begin
                m_starve = 0;
            end
            m_has = 1; m_acc = cyc; m_own_d = e_gd; m_drop = 0;
            m_we    = e_gd && d_we;
            m_addr  = e_gd ? d_addr : if_addr;
            m_wdata = m_we ? d_wdata : 32'h0;
            if (m_we) begin
                rmem[m_addr] = d_wdata;
                m_data = 32'h0;
            end else begin
                m_data = rmem.exists(m_addr) ? rmem[m_addr] : fill(m_addr);
            end
        end
        cyc++;
    endtask

    task automatic step(input bit ifv, input logic [31:0] ifa, input bit fl,
                        input bit dv, input bit we, input logic [31:0] da, input logic [31:0] wd);
        if_req_valid = ifv; if_addr = ifa; if_flush = fl;
        d_req_valid = dv; d_we = we; d_addr = da; d_wdata = wd;
        @(negedge clk);
        compare();
        @(posedge clk);
        update();
        #1;
        drive_mem();
    endtask

    task automatic idle();
        step(0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        bmem[a] = d;
        rmem[a] = d;
    endtask

    initial begin
        int          got, nresp, wcnt;
        bit          sack;
        logic [31:0] cap;
        string       seq;
        int          acc_q[$];
        logic [31:0] rsp_q[$];
        int          idx;

        rst = 1'b1;
        if_req_valid = 0; if_addr = 0; if_flush = 0;
        d_req_valid = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_read_data = 32'h0;
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_mem_rd_wr", 32'(mem_rd_wr),     32'd1);
        chk("rst_mem_en",    32'(mem_en),        32'd0);
        chk("rst_resp",      32'({if_resp_valid, d_resp_valid}), 32'd0);
        rst = 1'b0;
        drive_mem();

        // Single load: accept, LAT wait cycles, response in the following cycle.
        poke(32'h10, 32'hDEADBEEF);
        step(0, 0, 0, 1, 0, 32'h10, 0);
        chk("t1_accept", 32'(o_dr), 32'd1);
        got = -1; cap = 0;
        for (int k = 1; k <= 6; k++) begin
            idle();
            if (o_dresp && got < 0) begin got = k; cap = o_drdata; end
        end
        chk("t1_latency", 32'(got), 32'd4);
        chk("t1_rdata", cap, 32'hDEADBEEF);

        // Store then load of the same word.
        step(0, 0, 0, 1, 1, 32'h20, 32'hCAFEF00D);
        wcnt = 0; sack = 0;
        for (int k = 1; k <= 5; k++) begin
            idle();
            if (!o_rdwr) wcnt++;
            if (o_dresp && o_drdata == 32'h0) sack = 1;
        end
        chk("t2_write_cycles", 32'(wcnt), 32'd3);
        chk("t2_store_ack", 32'(sack), 32'd1);
        step(0, 0, 0, 1, 0, 32'h20, 0);
        got = -1; cap = 0;
        for (int k = 1; k <= 6; k++) begin
            idle();
            if (o_dresp && got < 0) begin got = k; cap = o_drdata; end
        end
        chk("t2_load_latency", 32'(got), 32'd4);
        chk("t2_load_data", cap, 32'hCAFEF00D);

        // Contention: both requesters valid continuously.
        seq = "";
        for (int k = 0; k < 48; k++) begin
            step(1, 32'h100 + 32'(4 * k), 0, 1, 0, 32'h200 + 32'(4 * k), 0);
            if (o_dr)  seq = {seq, "D"};
            if (o_ifr) seq = {seq, "I"};
        end
        chk("t3_grant_order", 32'(seq.substr(0, 9) == "DDDDIDDDDI"), 32'd1);
        repeat (5) idle();

        // Flush squashes an in-flight fetch; the next fetch returns normally.
        poke(32'h40, 32'h11112222);
        poke(32'h44, 32'h33334444);
        step(1, 32'h40, 0, 0, 0, 0, 0);
        chk("t4_accept", 32'(o_ifr), 32'd1);
        step(0, 0, 1, 0, 0, 0, 0);
        nresp = 0;
        for (int k = 0; k < 5; k++) begin idle(); if (o_ifresp) nresp++; end
        chk("t4_flushed_resp", 32'(nresp), 32'd0);
        step(1, 32'h44, 0, 0, 0, 0, 0);
        nresp = 0; cap = 0;
        for (int k = 0; k < 5; k++) begin
            idle();
            if (o_ifresp) begin nresp++; cap = o_ifrdata; end
        end
        chk("t4_next_resp", 32'(nresp), 32'd1);
        chk("t4_next_data", cap, 32'h33334444);

        // Reset in the middle of an access.
        step(0, 0, 0, 1, 0, 32'h10, 0);
        idle();
        idle();
        rst = 1'b1;
        #1;
        chk("t5_busy",     32'(busy),      32'd0);
        chk("t5_mem_en",   32'(mem_en),    32'd0);
        chk("t5_rd_wr",    32'(mem_rd_wr), 32'd1);
        chk("t5_rd_addr",  mem_read_addr,  32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_mem();
        repeat (5) idle();
        step(0, 0, 0, 1, 0, 32'h10, 0);
        chk("t5_accept_after", 32'(o_dr), 32'd1);
        repeat (5) idle();

        // Back-to-back fetches 0, 4, 8 with valid held.
        idx = 0;
        for (int k = 0; k < 20; k++) begin
            step(idx < 3, 32'(idx * 4), 0, 0, 0, 0, 0);
            if (o_ifr) begin acc_q.push_back(k); idx++; end
            if (o_ifresp) rsp_q.push_back(o_ifrdata);
        end
        chk("t6_accepts", 32'(acc_q.size()), 32'd3);
        chk("t6_resps", 32'(rsp_q.size()), 32'd3);
        if (acc_q.size() == 3) begin
            chk("t6_gap1", 32'(acc_q[1] - acc_q[0]), 32'd4);
            chk("t6_gap2", 32'(acc_q[2] - acc_q[1]), 32'd4);
        end
        if (rsp_q.size() == 3) begin
            chk("t6_word0", rsp_q[0], 32'h5A5A0000);
            chk("t6_word1", rsp_q[1], 32'h5A5E0004);
            chk("t6_word2", rsp_q[2], 32'h5A520008);
        end

        // Randomised traffic over a small address window so stores and loads alias.
        for (int k = 0; k < 800; k++) begin
            step($urandom_range(0, 99) < 60, 32'($urandom_range(0, 15) * 4),
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                 32'($urandom_range(0, 15) * 4), $urandom);
        end
        repeat (6) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported, byte-addressed instruction/data memory between the fetch stage and the load/store (data) port. Accepts one request at a time through a valid/ready handshake, drives the memory port for MEM_LATENCY cycles, then returns a one-cycle response pulse to the owner. Data requests have priority; a starvation counter guarantees fetch progress. Supports fetch-response squash on branch redirect.

Parameters:
DATA_WIDTH, 32, width of read/write data
ADDR_WIDTH, 32, width of byte addresses
MEM_LATENCY, 1, cycles memory port is held per access (legal range 1..15)
STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced (legal range 1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
if_req_valid  in  1  fetch request valid
if_req_ready  out  1  fetch request accepted this cycle
if_addr  in  ADDR_WIDTH  fetch byte address
if_flush  in  1  squash any in-flight fetch response (redirect)
if_resp_valid  out  1  one-cycle fetch response pulse
if_resp_data  out  DATA_WIDTH  fetched instruction
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted this cycle
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_WIDTH  data byte address
d_wdata  in  DATA_WIDTH  store data
d_resp_valid  out  1  one-cycle pulse: load data valid or store complete
d_resp_rdata  out  DATA_WIDTH  load data (0 for stores)
mem_en  out  1  memory enable
mem_rd_wr  out  1  1 = read, 0 = write
mem_read_addr  out  ADDR_WIDTH  memory read address
mem_write_addr  out  ADDR_WIDTH  memory write address
mem_write_data  out  DATA_WIDTH  memory write data
mem_read_data  in  DATA_WIDTH  combinational memory read data
busy  out  1  access in flight (state != IDLE)

Behaviour:
- Reset: state IDLE, mem_rd_wr=1, all other outputs 0, starvation counter 0, drop flag 0. Reset mid-access aborts the access; no response is issued.
- FSM states: IDLE and WAIT.
- IDLE: mem_en=0. Grant is computed combinationally. d_req_ready=grant_d; if_req_ready=grant_if. At most one ready is high.
- Grant rule:
  - Data only valid -> data.
  - Fetch only valid -> fetch.
  - Both valid -> data, unless starve_cnt==STARVE_LIMIT, then fetch.
- On the edge where valid&ready is true: latch owner, address, we and wdata; load the wait counter with MEM_LATENCY-1; go to WAIT.
- WAIT: mem_en=1. Memory signals come from the latched request: reads use mem_read_addr, writes use mem_write_addr/data, and mem_rd_wr=~we. Both ready outputs are 0. The counter decrements each cycle.
- Completion: in the WAIT cycle with counter==0, sample mem_read_data into the owner's resp_data register and return to IDLE. The owner's resp_valid is high for exactly the next cycle.
- Timing: a request accepted at edge N gives resp_valid in cycle N+MEM_LATENCY+1. A new request may be accepted in that same cycle, so throughput is one access per MEM_LATENCY+1 cycles.
- Starvation counter: saturating. It increments on each data grant while if_req_valid is high, and clears on each fetch grant.
- if_flush:
  - Sampled in WAIT with owner=fetch: sets the drop flag, and that response's if_resp_valid is suppressed (data is still registered).
  - In IDLE or with owner=data: no effect. Any flush in the cycle of an accept does not block that accept.
  - In the resp_valid cycle: that response is still delivered.
  - The drop flag clears on return to IDLE.
- Response ports have no ready signal. Consumers must accept the pulse.
- Store response: d_resp_valid pulses with d_resp_rdata=0.
- Address arithmetic is pass-through, with no alignment check and no wrap handling; that is the memory's responsibility.

Optional Feature:
Macro ARB_PERF_CNT_EN.
- Defined: adds outputs perf_if_grants[31:0], perf_d_grants[31:0] and perf_if_stall[31:0].
  - perf_if_stall counts cycles with if_req_valid high and if_req_ready low.
  - All three counters are cleared by rst and wrap modulo 2^32.
- Not defined: the ports are absent and no counter logic is built.

Decomposition:
- Package arb_pkg holds:
  - arb_state_t enum (ARB_IDLE, ARB_WAIT)
  - arb_owner_t enum (OWNER_IF, OWNER_D)
  - constants ARB_DEF_LATENCY=1 and ARB_DEF_STARVE=4
- One sub-module, arb_grant_logic: the combinational grant decision plus the saturating starvation counter. Its outputs are grant_if and grant_d.
- The FSM, latches and response registers stay in the top module.

Test Plan:
- Single load, MEM_LATENCY=1: d_addr=0x10 with memory preloaded 0xDEADBEEF, accepted at edge N -> mem_en high in cycle N+1, d_resp_valid in cycle N+2 with rdata=0xDEADBEEF.
- Store then load, MEM_LATENCY=3: store 0xCAFEF00D to 0x20, then load 0x20 -> mem_rd_wr=0 for 3 cycles, store ack; load returns 0xCAFEF00D 4 cycles after its accept.
- Contention, STARVE_LIMIT=4: both valid continuously -> grants follow D,D,D,D,IF,D,D,D,D,IF,…; the fetch is never starved beyond 4 data grants.
- Flush: a fetch of 0x40 is in WAIT and if_flush pulses -> no if_resp_valid. Next fetch of 0x44 returns normally with correct data.
- Reset mid-access: rst asserted in WAIT of MEM_LATENCY=3 -> outputs go to reset values immediately, no resp pulse, and a new request is accepted after rst deasserts.
- Back-to-back fetch, MEM_LATENCY=1: if_req_valid held with addresses 0,4,8 -> accepts every 2 cycles, and responses arrive in order with correct words.
